// File: rtl/flappy_pkg.sv
// -----------------------------------------------------------------------------
// flappy_pkg
// Shared definitions for the Flappy Bird frame engine:
//   - 12-bit RGB colour constants
//   - game state encoding (IDLE / PLAY / DEAD)
//   - coordinate width (VGA counters) and the widened geometry width used for
//     overflow-free comparisons
//   - widen(): zero-extends a screen coordinate to geometry width
// -----------------------------------------------------------------------------
package flappy_pkg;

    localparam int COORD_W = 10;
    // One extra bit so that x + half_width and y + gap never wrap.
    localparam int GEOM_W  = COORD_W + 1;

    localparam logic [11:0] BLACK  = 12'h000;
    localparam logic [11:0] WHITE  = 12'hFFF;
    localparam logic [11:0] RED    = 12'hF00;
    localparam logic [11:0] GREEN  = 12'h0F0;
    localparam logic [11:0] YELLOW = 12'hFF0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_DEAD = 2'b10
    } game_state_e;

    function automatic logic [GEOM_W-1:0] widen(input logic [COORD_W-1:0] v);
        return {1'b0, v};
    endfunction

endpackage

// File: rtl/flappy_pipe_slice.sv
// -----------------------------------------------------------------------------
// flappy_pipe_slice
// Per-pipe geometry and pass tracking for one upper/lower pipe pair.
//   clk, reset_n   : pixel clock, asynchronous active-low reset
//   hcount_i       : current pixel column
//   vcount_i       : current pixel row
//   pipe_x_i       : pipe centre X
//   pipe_y_i       : bottom edge of the upper pipe
//   score_en_i     : frame_tick qualified with PLAY; pass/respawn evaluation
//   clear_i        : game start; clears the passed flag
//   pipe_pix_o     : current pixel lies on this pipe pair
//   passed_o       : pipe has already been credited as passed
//   new_pass_o     : pipe is being credited on this cycle
// -----------------------------------------------------------------------------
module flappy_pipe_slice
    import flappy_pkg::*;
#(
    parameter int PIPE_HALF_W = 50,
    parameter int GAP_H       = 100,
    parameter int BIRD_X      = 400,
    parameter int BIRD_W      = 50
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [COORD_W-1:0] hcount_i,
    input  logic [COORD_W-1:0] vcount_i,
    input  logic [COORD_W-1:0] pipe_x_i,
    input  logic [COORD_W-1:0] pipe_y_i,
    input  logic               score_en_i,
    input  logic               clear_i,
    output logic               pipe_pix_o,
    output logic               passed_o,
    output logic               new_pass_o
);

    localparam logic [GEOM_W-1:0] HALF_G       = GEOM_W'(PIPE_HALF_W);
    localparam logic [GEOM_W-1:0] GAP_G        = GEOM_W'(GAP_H);
    localparam logic [GEOM_W-1:0] BIRD_LEFT_G  = GEOM_W'(BIRD_X);
    localparam logic [GEOM_W-1:0] BIRD_RIGHT_G = GEOM_W'(BIRD_X + BIRD_W);

    logic [GEOM_W-1:0] x_g, y_g, h_g, v_g;
    logic [GEOM_W-1:0] left_g, right_g;
    logic              in_x, in_y;
    logic              past_bird, respawned;
    logic              passed_q, passed_d;

    always_comb begin
        x_g = widen(pipe_x_i);
        y_g = widen(pipe_y_i);
        h_g = widen(hcount_i);
        v_g = widen(vcount_i);

        // Left edge clamps at column 0 instead of wrapping to a huge value.
        left_g  = (x_g >= HALF_G) ? (x_g - HALF_G) : '0;
        right_g = x_g + HALF_G;

        in_x = (h_g >= left_g) && (h_g <= right_g);
        in_y = (v_g <= y_g) || (v_g >= (y_g + GAP_G));
        pipe_pix_o = in_x && in_y;

        past_bird = right_g < BIRD_LEFT_G;
        // With the clamped left edge a pipe near column 0 can never look
        // respawned, so the unclamped subtraction is not needed here.
        respawned = left_g >= BIRD_RIGHT_G;

        new_pass_o = score_en_i && !passed_q && past_bird;
    end

    always_comb begin
        passed_d = passed_q;
        if (clear_i) begin
            passed_d = 1'b0;
        end else if (score_en_i) begin
            if (new_pass_o) begin
                passed_d = 1'b1;
            end else if (respawned) begin
                passed_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            passed_q <= 1'b0;
        end else begin
            passed_q <= passed_d;
        end
    end

    assign passed_o = passed_q;

endmodule

// File: rtl/flappy_frame_engine.sv
// -----------------------------------------------------------------------------
// flappy_frame_engine
// Per-pixel renderer and game logic for the Flappy Bird VGA design.
//   clk, reset_n : pixel clock, asynchronous active-low reset
//   bright       : visible-area flag from VGA timing
//   hCount/vCount: current pixel column/row
//   frame_tick   : one-cycle pulse at the end of each frame
//   button       : raw start button (asynchronous)
//   birb_y       : bird top edge
//   pipe_x/pipe_y: packed per-pipe centre X / upper-pipe bottom edge
//   rgb          : registered pixel colour (1-cycle latency)
//   score        : current score, high_score: best since reset
//   game_state   : 00 IDLE, 01 PLAY, 10 DEAD
//   hit          : one-cycle pulse in the first DEAD cycle
// -----------------------------------------------------------------------------
module flappy_frame_engine
    import flappy_pkg::*;
#(
    parameter int          NUM_PIPES   = 3,
    parameter int          PIPE_HALF_W = 50,
    parameter int          GAP_H       = 100,
    parameter int          BIRD_X      = 400,
    parameter int          BIRD_W      = 50,
    parameter int          BIRD_H      = 25,
    parameter int          FLOOR_Y     = 515,
    parameter int          DEAD_FRAMES = 120,
    parameter logic [11:0] BG_COLOR    = 12'hF00
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           bright,
    input  logic [COORD_W-1:0]             hCount,
    input  logic [COORD_W-1:0]             vCount,
    input  logic                           frame_tick,
    input  logic                           button,
    input  logic [COORD_W-1:0]             birb_y,
    input  logic [COORD_W*NUM_PIPES-1:0]   pipe_x,
    input  logic [COORD_W*NUM_PIPES-1:0]   pipe_y,
    output logic [11:0]                    rgb,
    output logic [15:0]                    score,
    output logic [15:0]                    high_score,
    output logic [1:0]                     game_state,
    output logic                           hit
);

    localparam int CNT_W = (DEAD_FRAMES > 1) ? $clog2(DEAD_FRAMES) : 1;
    localparam logic [CNT_W-1:0]  DEAD_LAST    = CNT_W'(DEAD_FRAMES - 1);
    localparam logic [GEOM_W-1:0] BIRD_LEFT_G  = GEOM_W'(BIRD_X);
    localparam logic [GEOM_W-1:0] BIRD_RIGHT_G = GEOM_W'(BIRD_X + BIRD_W);
    localparam logic [GEOM_W-1:0] BIRD_H_G     = GEOM_W'(BIRD_H);
    localparam logic [GEOM_W-1:0] FLOOR_G      = GEOM_W'(FLOOR_Y);

    // ------------------------------------------------------------------
    // Button synchroniser and rising-edge detect
    // ------------------------------------------------------------------
    logic [1:0] btn_sync_q;
    logic       btn_prev_q;
    logic       btn_edge;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours (shift chains stay intact).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_sync_q <= 2'b00;
            btn_prev_q <= 1'b0;
        end else begin
            btn_sync_q <= {btn_sync_q[0], button};
            btn_prev_q <= btn_sync_q[1];
        end
    end

    assign btn_edge = btn_sync_q[1] && !btn_prev_q;

    // ------------------------------------------------------------------
    // Per-pipe slices
    // ------------------------------------------------------------------
    game_state_e          state_q, state_d;
    logic                 score_en;
    logic                 start;
    logic [NUM_PIPES-1:0] pipe_pix;
    logic [NUM_PIPES-1:0] passed;
    logic [NUM_PIPES-1:0] new_pass;

    for (genvar i = 0; i < NUM_PIPES; i++) begin : g_pipe
        flappy_pipe_slice #(
            .PIPE_HALF_W (PIPE_HALF_W),
            .GAP_H       (GAP_H),
            .BIRD_X      (BIRD_X),
            .BIRD_W      (BIRD_W)
        ) u_slice (
            .clk        (clk),
            .reset_n    (reset_n),
            .hcount_i   (hCount),
            .vcount_i   (vCount),
            .pipe_x_i   (pipe_x[COORD_W*i +: COORD_W]),
            .pipe_y_i   (pipe_y[COORD_W*i +: COORD_W]),
            .score_en_i (score_en),
            .clear_i    (start),
            .pipe_pix_o (pipe_pix[i]),
            .passed_o   (passed[i]),
            .new_pass_o (new_pass[i])
        );
    end

    // ------------------------------------------------------------------
    // Bird geometry, collisions and pass count
    // ------------------------------------------------------------------
    logic [GEOM_W-1:0] h_g, v_g, bird_top_g, bird_bot_g;
    logic              any_pipe, bird_pix, pix_hit, floor_hit;
    logic [3:0]        pass_cnt;
    logic [16:0]       score_sum;
    logic [15:0]       score_sat;

    // NOTE: every signal assigned in an always_comb gets a default first, so
    // no path leaves it holding its old value (which would infer a latch).
    always_comb begin
        h_g        = widen(hCount);
        v_g        = widen(vCount);
        bird_top_g = widen(birb_y);
        bird_bot_g = bird_top_g + BIRD_H_G;

        any_pipe = |pipe_pix;
        bird_pix = (h_g >= BIRD_LEFT_G) && (h_g < BIRD_RIGHT_G) &&
                   (v_g >= bird_top_g) && (v_g < bird_bot_g);
        pix_hit   = bright && any_pipe && bird_pix;
        floor_hit = frame_tick && (bird_bot_g > FLOOR_G);

        pass_cnt = '0;
        for (int i = 0; i < NUM_PIPES; i++) begin
            pass_cnt = pass_cnt + 4'(new_pass[i]);
        end

        score_sum = {1'b0, score} + 17'(pass_cnt);
        score_sat = score_sum[16] ? 16'hFFFF : score_sum[15:0];
    end

    // ------------------------------------------------------------------
    // Game FSM, scores, collision latch, dead counter
    // ------------------------------------------------------------------
    logic [15:0]      score_q, score_d;
    logic [15:0]      high_q, high_d;
    logic             latch_q, latch_d;
    logic             hit_q, hit_d;
    logic [CNT_W-1:0] dead_cnt_q, dead_cnt_d;

    always_comb begin
        state_d    = state_q;
        score_d    = score_q;
        high_d     = high_q;
        latch_d    = latch_q;
        dead_cnt_d = dead_cnt_q;
        hit_d      = 1'b0;
        start      = 1'b0;
        score_en   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (btn_edge) begin
                    state_d = ST_PLAY;
                    score_d = '0;
                    latch_d = 1'b0;
                    start   = 1'b1;
                end
            end
            ST_PLAY: begin
                latch_d = latch_q || pix_hit || floor_hit;
                if (frame_tick) begin
                    score_en = 1'b1;
                    score_d  = score_sat;
                    // The pass is credited before death is judged, so the
                    // high score sees the post-pass value.
                    if (latch_d) begin
                        state_d    = ST_DEAD;
                        hit_d      = 1'b1;
                        high_d     = (score_sat > high_q) ? score_sat : high_q;
                        dead_cnt_d = '0;
                    end
                end
            end
            ST_DEAD: begin
                if (frame_tick) begin
                    if (dead_cnt_q == DEAD_LAST) begin
                        state_d    = ST_IDLE;
                        dead_cnt_d = '0;
                    end else begin
                        dead_cnt_d = dead_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            score_q    <= '0;
            high_q     <= '0;
            latch_q    <= 1'b0;
            hit_q      <= 1'b0;
            dead_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            score_q    <= score_d;
            high_q     <= high_d;
            latch_q    <= latch_d;
            hit_q      <= hit_d;
            dead_cnt_q <= dead_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Pixel colour
    // ------------------------------------------------------------------
    logic [11:0] rgb_q, rgb_d;

    always_comb begin
        rgb_d = BG_COLOR;
        if (!bright) begin
            rgb_d = BLACK;
        end else if (any_pipe) begin
            rgb_d = GREEN;
        end else if (bird_pix) begin
            rgb_d = (state_q == ST_DEAD) ? YELLOW : WHITE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rgb_q <= BLACK;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign rgb        = rgb_q;
    assign score      = score_q;
    assign high_score = high_q;
    assign game_state = state_q;
    assign hit        = hit_q;

endmodule

// File: tb/tb_flappy_frame_engine.sv
module tb_flappy_frame_engine;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        bright;
    logic [9:0]  hCount, vCount;
    logic        frame_tick;
    logic        button;
    logic [9:0]  birb_y;
    logic [29:0] pipe_x, pipe_y;
    logic [11:0] rgb;
    logic [15:0] score, high_score;
    logic [1:0]  game_state;
    logic        hit;

    int checks = 0;
    int errors = 0;

    flappy_frame_engine dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bright     (bright),
        .hCount     (hCount),
        .vCount     (vCount),
        .frame_tick (frame_tick),
        .button     (button),
        .birb_y     (birb_y),
        .pipe_x     (pipe_x),
        .pipe_y     (pipe_y),
        .rgb        (rgb),
        .score      (score),
        .high_score (high_score),
        .game_state (game_state),
        .hit        (hit)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_frame();
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        tick();
    endtask

    task automatic press_button();
        button = 1'b1;
        repeat (4) tick();
        button = 1'b0;
        tick();
    endtask

    task automatic set_pipe(input int i, input logic [9:0] x);
        pipe_x[10*i +: 10] = x;
    endtask

    task automatic pixel(input logic [9:0] h, input logic [9:0] v);
        hCount = h;
        vCount = v;
        tick();
    endtask

    initial begin
        reset_n    = 1'b1;
        bright     = 1'b1;
        hCount     = 10'd420;
        vCount     = 10'd410;
        frame_tick = 1'b0;
        button     = 1'b0;
        birb_y     = 10'd400;
        pipe_x     = {3{10'd900}};
        pipe_y     = {3{10'd100}};

        // ---------------- reset and idle rendering ----------------
        #2 reset_n = 1'b0;
        #1;
        check("rst_rgb",   16'(rgb), 16'h000);
        check("rst_score", score, 16'd0);
        check("rst_high",  high_score, 16'd0);
        check("rst_state", 16'(game_state), 16'd0);
        check("rst_hit",   16'(hit), 16'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        tick();
        check("idle_bird_white", 16'(rgb), 16'hFFF);
        check("idle_state", 16'(game_state), 16'd0);
        check("idle_score", score, 16'd0);

        pixel(10'd100, 10'd300); check("bg_colour", 16'(rgb), 16'hF00);
        bright = 1'b0;
        tick();                  check("blank_black", 16'(rgb), 16'h000);
        bright = 1'b1;
        pixel(10'd900, 10'd50);  check("upper_pipe", 16'(rgb), 16'h0F0);
        pixel(10'd900, 10'd100); check("upper_pipe_bottom_row", 16'(rgb), 16'h0F0);
        pixel(10'd900, 10'd150); check("gap_bg", 16'(rgb), 16'hF00);
        pixel(10'd900, 10'd199); check("gap_last_row", 16'(rgb), 16'hF00);
        pixel(10'd900, 10'd200); check("lower_pipe_top_row", 16'(rgb), 16'h0F0);
        pixel(10'd850, 10'd50);  check("pipe_left_edge", 16'(rgb), 16'h0F0);
        pixel(10'd849, 10'd50);  check("pipe_left_outside", 16'(rgb), 16'hF00);
        pixel(10'd950, 10'd50);  check("pipe_right_edge", 16'(rgb), 16'h0F0);
        pixel(10'd951, 10'd50);  check("pipe_right_outside", 16'(rgb), 16'hF00);
        pixel(10'd420, 10'd410);

        // ---------------- start and single passes ----------------
        press_button();
        check("start_state", 16'(game_state), 16'd1);
        check("start_score", score, 16'd0);
        set_pipe(0, 10'd330);
        pulse_frame(); check("pass_once", score, 16'd1);
        pulse_frame();
        pulse_frame(); check("pass_not_repeated", score, 16'd1);
        set_pipe(0, 10'd600);
        pulse_frame(); check("respawn_no_score", score, 16'd1);
        set_pipe(0, 10'd330);
        pulse_frame(); check("second_pass", score, 16'd2);

        // ---------------- double pass and boundary ----------------
        set_pipe(0, 10'd900);
        pulse_frame(); check("respawn_again", score, 16'd2);
        set_pipe(0, 10'd330);
        set_pipe(1, 10'd330);
        pulse_frame(); check("double_pass", score, 16'd4);
        set_pipe(2, 10'd350);
        pulse_frame(); check("right_edge_at_bird_x", score, 16'd4);
        set_pipe(2, 10'd349);
        pulse_frame(); check("right_edge_below_bird_x", score, 16'd5);

        // ---------------- pipe collision ----------------
        birb_y = 10'd200;
        set_pipe(0, 10'd425);
        pipe_y[9:0] = 10'd300;
        pixel(10'd420, 10'd210);
        check("collide_pipe_over_bird", 16'(rgb), 16'h0F0);
        check("collide_wait_tick", 16'(game_state), 16'd1);
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        check("hit_pulse", 16'(hit), 16'd1);
        check("dead_state", 16'(game_state), 16'd2);
        check("dead_score", score, 16'd5);
        check("dead_high", high_score, 16'd5);
        tick();
        check("hit_one_cycle", 16'(hit), 16'd0);
        set_pipe(0, 10'd900);
        tick();
        check("dead_bird_yellow", 16'(rgb), 16'hFF0);
        press_button();
        check("button_ignored_dead", 16'(game_state), 16'd2);
        repeat (119) pulse_frame();
        check("dead_after_119", 16'(game_state), 16'd2);
        pulse_frame();
        check("idle_after_120", 16'(game_state), 16'd0);
        check("score_held_idle", score, 16'd5);

        // ---------------- floor and left-edge clamp ----------------
        birb_y = 10'd400;
        pipe_y = {3{10'd100}};
        pixel(10'd420, 10'd410);
        press_button();
        check("restart_state", 16'(game_state), 16'd1);
        check("restart_score_clear", score, 16'd0);
        birb_y = 10'd490;
        pulse_frame(); check("floor_boundary_alive", 16'(game_state), 16'd1);
        birb_y = 10'd495;
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        check("floor_dead", 16'(game_state), 16'd2);
        check("floor_hit", 16'(hit), 16'd1);
        check("high_kept_max", high_score, 16'd5);
        set_pipe(2, 10'd20);
        pixel(10'd0, 10'd50);    check("clamp_col0_green", 16'(rgb), 16'h0F0);
        pixel(10'd70, 10'd50);   check("clamp_right_edge", 16'(rgb), 16'h0F0);
        pixel(10'd71, 10'd50);   check("clamp_right_outside", 16'(rgb), 16'hF00);
        pixel(10'd1000, 10'd50); check("no_wrap_col1000", 16'(rgb), 16'hF00);
        birb_y = 10'd400;
        set_pipe(2, 10'd900);
        pixel(10'd420, 10'd410);
        repeat (120) pulse_frame();
        check("floor_back_idle", 16'(game_state), 16'd0);

        // ---------------- score 7 then async reset mid-PLAY ----------------
        press_button();
        pipe_x = {3{10'd330}};
        pulse_frame(); check("triple_pass", score, 16'd3);
        pipe_x = {3{10'd900}};
        pulse_frame();
        pipe_x = {3{10'd330}};
        pulse_frame(); check("triple_pass_again", score, 16'd6);
        set_pipe(0, 10'd900);
        pulse_frame();
        set_pipe(0, 10'd330);
        pulse_frame();
        check("score_seven", score, 16'd7);
        check("play_before_reset", 16'(game_state), 16'd1);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_score", score, 16'd0);
        check("async_rst_high", high_score, 16'd0);
        check("async_rst_state", 16'(game_state), 16'd0);
        check("async_rst_rgb", 16'(rgb), 16'h000);
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        tick();
        check("post_reset_rgb", 16'(rgb), 16'hFFF);
        check("post_reset_state", 16'(game_state), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/flappy_frame_engine.md
Name: flappy_frame_engine

Overview:
Per-pixel renderer and game-logic engine for the Flappy Bird VGA design, replacing the single-pipe painter with a generalised version. It draws NUM_PIPES pipe pairs, the bird and the background. It detects bird/pipe and bird/floor collisions, counts passed pipes and keeps a high score. It sits between the VGA timing block (hCount, vCount, bright) and the physics/pipe-motion logic (bird Y, pipe X/Y), and drives the 12-bit RGB output and the score display.

Parameters:
NUM_PIPES, 3, number of pipe pairs on screen (1..8)
PIPE_HALF_W, 50, pipe half-width in pixels
GAP_H, 100, vertical opening between upper and lower pipe
BIRD_X, 400, fixed left edge of the bird
BIRD_W, 50, bird width
BIRD_H, 25, bird height
FLOOR_Y, 515, vCount at or beyond which the bird is dead
DEAD_FRAMES, 120, frames spent in DEAD before returning to IDLE
BG_COLOR, 12'hF00, background colour

Ports:
clk  in  1  pixel-domain clock
reset_n  in  1  asynchronous active-low reset
bright  in  1  visible-area flag from VGA timing
hCount  in  10  current pixel column
vCount  in  10  current pixel row
frame_tick  in  1  one-cycle pulse at end of each frame
button  in  1  raw start button, asynchronous to clk
birb_y  in  10  bird top edge
pipe_x  in  10*NUM_PIPES  pipe centre X; pipe i occupies bits [10i+9:10i]
pipe_y  in  10*NUM_PIPES  bottom edge of upper pipe i
rgb  out  12  registered pixel colour
score  out  16  current game score
high_score  out  16  best score since reset
game_state  out  2  00 IDLE, 01 PLAY, 10 DEAD
hit  out  1  one-cycle pulse on PLAY->DEAD

Behaviour:
- Reset (async, reset_n=0): rgb=0, score=0, high_score=0, game_state=IDLE, hit=0, passed flags=0, hit latch=0, dead counter=0, button synchroniser=0.
- Button: 2-FF synchroniser, then rising-edge detect. Only the edge is used.
- Geometry uses 11-bit unsigned arithmetic. pipe left = max(pipe_x-PIPE_HALF_W, 0) with no wrap. Right = pipe_x+PIPE_HALF_W. Pipe pixel: inside X span and (vCount<=pipe_y or vCount>=pipe_y+GAP_H). Bird pixel: BIRD_X<=hCount<BIRD_X+BIRD_W and birb_y<=vCount<birb_y+BIRD_H.
- rgb is registered, with 1-cycle latency from hCount/vCount/bright. Priority: ~bright -> BLACK; pipe -> GREEN; bird -> WHITE in IDLE/PLAY, YELLOW (12'hFF0) in DEAD; else BG_COLOR.
- Collision latch: in PLAY, set when bright and the same pixel is both pipe and bird. Also set when birb_y+BIRD_H>FLOOR_Y, evaluated at frame_tick. Cleared on entering PLAY.
- FSM:
  - IDLE: on button edge -> PLAY. score=0, passed flags=0, latch=0.
  - PLAY: on frame_tick with latch set -> DEAD. hit=1 for that cycle. high_score=max(high_score,score) in the same cycle. dead counter=0.
  - DEAD: dead counter increments on each frame_tick. When it reaches DEAD_FRAMES-1 at a frame_tick -> IDLE. Button ignored in DEAD.
- Scoring, at frame_tick in PLAY only:
  - For each pipe i with passed[i]=0 and pipe_x[i]+PIPE_HALF_W<BIRD_X: set passed[i].
  - passed[i] clears when pipe_x[i]-PIPE_HALF_W>=BIRD_X+BIRD_W (pipe respawned right of the bird).
  - score += popcount(newly passed) in one cycle.
  - score saturates at 16'hFFFF.
- Simultaneous events at one frame_tick: collision and pass. The pass is credited first; high_score uses the updated score.
- score holds its value through DEAD and IDLE until the next start.
- reset_n asserted mid-frame or mid-game returns everything to reset values immediately. The first rgb after release is valid one cycle later.

Decomposition:
- Shared package flappy_pkg holds: colour constants (BLACK, WHITE, RED, GREEN, YELLOW), game_state encoding constants, coordinate width (10).
- One sub-module, flappy_pipe_slice, instantiated NUM_PIPES times via generate. Per pipe it produces: pipe-pixel hit, passed flag, new-pass pulse.
- Top level does priority muxing, popcount, FSM, scores and synchroniser.

Test Plan:
- Reset then idle. Drive hCount=420, vCount=410, bright=1, birb_y=400, all pipes at pipe_x=900 -> one cycle later rgb=12'hFFF; game_state=00; score=0.
- Start and pass. Button edge, then 3 frame_ticks with pipe0 at pipe_x=330 (right edge 380<400) -> score=1 exactly once. Respawn pipe0 to 600, then back to 330 -> score=2.
- Double pass. NUM_PIPES=3; pipes 0 and 1 both cross BIRD_X on the same frame_tick -> score increments by 2 in one cycle.
- Pipe collision. Bird at y=200, pipe0 pipe_x=425, pipe_y=300 (bird in upper pipe) -> hit pulse at next frame_tick; game_state=10; high_score=score. After 120 frame_ticks -> game_state=00.
- Floor and edge. birb_y=495 (495+25>515) -> DEAD at frame_tick. pipe_x=20 -> left edge clamps to 0 with no wrap, and column 1000 is not painted green.
- Async reset mid-PLAY with score=7. Pulse reset_n low for 3 cycles off-edge -> score=0, high_score=0, game_state=00, rgb=0 immediately.
